// File: rtl/mips_debug_ctrl.sv
// Host-byte sequencer for the TP4 core: loads instruction memory,
// then runs the core continuously or one clock per step command.
module mips_debug_ctrl #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_VALID,
  input  logic              CPU_HALT,
  output logic [31:0]       INSTRUCTION_OUT,
  output logic              IMEM_WE,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  output logic              CPU_EN,
  output logic              CPU_CLR,
  output logic              LOAD_OVF,
  output logic              DONE,
  output logic [31:0]       CYCLE_CNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_STEP_WAIT,
    S_STEP_EXEC,
    S_DONE
  } state_t;

  state_t            state;
  logic [23:0]       shift;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       word;

  logic is_l, is_c, is_s, is_n, is_r;

  assign is_l = RX_VALID && (RX_DATA == 8'h4C);
  assign is_c = RX_VALID && (RX_DATA == 8'h43);
  assign is_s = RX_VALID && (RX_DATA == 8'h53);
  assign is_n = RX_VALID && (RX_DATA == 8'h4E);
  assign is_r = RX_VALID && (RX_DATA == 8'h52);
  assign word = {shift, RX_DATA};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state           <= S_IDLE;
      shift           <= '0;
      byte_cnt        <= '0;
      addr            <= '0;
      INSTRUCTION_OUT <= '0;
      IMEM_WE         <= 1'b0;
      IMEM_ADDR       <= '0;
      CPU_EN          <= 1'b0;
      CPU_CLR         <= 1'b0;
      LOAD_OVF        <= 1'b0;
      DONE            <= 1'b0;
      CYCLE_CNT       <= '0;
    end else begin
      IMEM_WE <= 1'b0;
      CPU_CLR <= 1'b0;
      if (CPU_EN && (CYCLE_CNT != 32'hFFFF_FFFF))
        CYCLE_CNT <= CYCLE_CNT + 32'd1;
      unique case (state)
        S_IDLE: begin
          CPU_EN <= 1'b0;
          if (is_l) begin
            state    <= S_LOAD;
            addr     <= '0;
            byte_cnt <= '0;
            LOAD_OVF <= 1'b0;
          end else if (is_c) begin
            state  <= S_RUN;
            CPU_EN <= 1'b1;
          end else if (is_s) begin
            state <= S_STEP_WAIT;
          end
        end
        S_LOAD: begin
          if (RX_VALID) begin
            shift    <= word[23:0];
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              IMEM_WE         <= 1'b1;
              INSTRUCTION_OUT <= word;
              IMEM_ADDR       <= addr;
              addr            <= addr + ADDR_W'(1);
              // halt marker wins over overflow on the last slot
              if (word == HALT_WORD) begin
                state <= S_IDLE;
              end else if (addr == '1) begin
                LOAD_OVF <= 1'b1;
                state    <= S_IDLE;
              end
            end
          end
        end
        S_RUN: begin
          if (CPU_HALT) begin
            CPU_EN <= 1'b0;
            DONE   <= 1'b1;
            state  <= S_DONE;
          end else if (is_s) begin
            CPU_EN <= 1'b0;
            state  <= S_STEP_WAIT;
          end
        end
        S_STEP_WAIT: begin
          if (CPU_HALT) begin
            DONE  <= 1'b1;
            state <= S_DONE;
          end else if (is_n) begin
            CPU_EN <= 1'b1;
            state  <= S_STEP_EXEC;
          end else if (is_c) begin
            CPU_EN <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_STEP_EXEC: begin
          CPU_EN <= 1'b0;
          if (CPU_HALT) begin
            DONE  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_STEP_WAIT;
          end
        end
        S_DONE: begin
          CPU_EN <= 1'b0;
          if (is_r) begin
            DONE      <= 1'b0;
            CPU_CLR   <= 1'b1;
            CYCLE_CNT <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Directed bench for mips_debug_ctrl: vector table plus
// hand sequences for load overflow, run/step, reset and restart.
module tb_mips_debug_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        cpu_halt = 1'b0;

  logic [31:0] instr, instr2;
  logic        we, we2;
  logic [7:0]  addr;
  logic [1:0]  addr2;
  logic        en, en2, clr, clr2, ovf, ovf2, done, done2;
  logic [31:0] cnt, cnt2;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  mips_debug_ctrl #(.ADDR_W(8)) dut (
    .CLK(clk), .RESET(rst_n), .RX_DATA(rx_data),
    .RX_VALID(rx_valid), .CPU_HALT(cpu_halt),
    .INSTRUCTION_OUT(instr), .IMEM_WE(we), .IMEM_ADDR(addr),
    .CPU_EN(en), .CPU_CLR(clr), .LOAD_OVF(ovf),
    .DONE(done), .CYCLE_CNT(cnt)
  );

  mips_debug_ctrl #(.ADDR_W(2)) dut2 (
    .CLK(clk), .RESET(rst_n), .RX_DATA(rx_data),
    .RX_VALID(rx_valid), .CPU_HALT(cpu_halt),
    .INSTRUCTION_OUT(instr2), .IMEM_WE(we2), .IMEM_ADDR(addr2),
    .CPU_EN(en2), .CPU_CLR(clr2), .LOAD_OVF(ovf2),
    .DONE(done2), .CYCLE_CNT(cnt2)
  );

  typedef struct {
    logic        vld;
    logic [7:0]  data;
    logic        halt;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] instr;
    logic        en;
    logic        clr;
    logic        ovf;
    logic        done;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(
    input logic v, input logic [7:0] d, input logic h,
    input logic w, input logic [7:0] a, input logic [31:0] ins,
    input logic e, input logic c, input logic o, input logic dn,
    input logic [31:0] n);
    vec_t r;
    r.vld = v; r.data = d; r.halt = h;
    r.we = w; r.addr = a; r.instr = ins;
    r.en = e; r.clr = c; r.ovf = o; r.done = dn; r.cnt = n;
    return r;
  endfunction

  task automatic chk(input string name, input logic [79:0] act,
                     input logic [79:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d,
                      input logic h);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    cpu_halt = h;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    cpu_halt = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("reset_quiet", {78'd0, we, en}, 80'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit ok;
    bit all_on;
    int hi;

    tbl[0]  = mk(1'b1, 8'h4C, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[1]  = mk(1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[2]  = mk(1'b1, 8'h34, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[3]  = mk(1'b1, 8'h56, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[4]  = mk(1'b1, 8'h78, 1'b0, 1'b1, 8'h00, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[5]  = mk(1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[6]  = mk(1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[7]  = mk(1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[8]  = mk(1'b1, 8'hFF, 1'b0, 1'b1, 8'h01, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[9]  = mk(1'b1, 8'h4E, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[10] = mk(1'b1, 8'h43, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[11] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1);
    tbl[12] = mk(1'b1, 8'h53, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2);
    tbl[13] = mk(1'b1, 8'h4E, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd2);
    tbl[14] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3);
    tbl[15] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3);
    tbl[16] = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd3);
    tbl[17] = mk(1'b1, 8'h52, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    tbl[18] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    do_reset();
    #1;
    chk("reset_state",
        {3'd0, instr, we, addr, en, clr, ovf, done, cnt}, 80'd0);

    // load, run, step, halt and restart via the table
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].vld, tbl[i].data, tbl[i].halt);
      ok = (we == tbl[i].we) && (en == tbl[i].en) &&
           (clr == tbl[i].clr) && (ovf == tbl[i].ovf) &&
           (done == tbl[i].done) && (cnt == tbl[i].cnt) &&
           (!tbl[i].we ||
            ((addr == tbl[i].addr) && (instr == tbl[i].instr)));
      nvec++;
      if (!ok) begin
        nbad++;
        $display("FAIL vec%0d: we=%0b en=%0b clr=%0b ovf=%0b done=%0b cnt=%0d addr=%0h instr=%h expected we=%0b en=%0b clr=%0b ovf=%0b done=%0b cnt=%0d addr=%0h instr=%h",
                 i, we, en, clr, ovf, done, cnt, addr, instr,
                 tbl[i].we, tbl[i].en, tbl[i].clr, tbl[i].ovf,
                 tbl[i].done, tbl[i].cnt, tbl[i].addr, tbl[i].instr);
      end
    end

    // overflow on a 4-word memory
    do_reset();
    step(1'b1, 8'h4C, 1'b0);
    for (int w = 1; w <= 4; w++) begin
      step(1'b1, 8'h00, 1'b0);
      step(1'b1, 8'h00, 1'b0);
      step(1'b1, 8'h00, 1'b0);
      step(1'b1, 8'(w), 1'b0);
      chk($sformatf("ovf_word%0d", w),
          {45'd0, we2, addr2, instr2},
          {45'd0, 1'b1, 2'(w - 1), 32'(w)});
      chk($sformatf("ovf_flag%0d", w), {79'd0, ovf2},
          {79'd0, (w == 4) ? 1'b1 : 1'b0});
    end
    all_on = 1'b0;
    for (int b = 0; b < 4; b++) begin
      step(1'b1, (b == 3) ? 8'h05 : 8'h00, 1'b0);
      if (we2) all_on = 1'b1;
    end
    chk("ovf_no_5th_we", {78'd0, all_on, ovf2}, {78'd0, 1'b0, 1'b1});

    // continuous run halted after 11 enabled cycles, halt beats 'S'
    do_reset();
    step(1'b1, 8'h43, 1'b0);
    hi = en ? 1 : 0;
    for (int i = 0; i < 40 && en; i++) begin
      if (hi == 11) step(1'b1, 8'h53, 1'b1);
      else step(1'b0, 8'h00, 1'b0);
      if (en) hi++;
    end
    chk("run_en_cycles", 80'(hi), 80'd11);
    chk("run_done_cnt", {47'd0, en, done, cnt},
        {47'd0, 1'b0, 1'b1, 32'd11});
    step(1'b0, 8'h00, 1'b0);
    chk("run_done_hold", {78'd0, en, done}, {78'd0, 1'b0, 1'b1});

    // restart from DONE, then 'N' in IDLE must not enable the core
    step(1'b1, 8'h52, 1'b0);
    chk("restart", {45'd0, clr, done, en, cnt}, {45'd0, 3'b100, 32'd0});
    step(1'b0, 8'h00, 1'b0);
    chk("restart_clr_1cyc", {78'd0, clr, done}, 80'd0);
    step(1'b1, 8'h4E, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("idle_n_no_en", {79'd0, en}, 80'd0);

    // single stepping; 'C' in the exec cycle is dropped
    do_reset();
    step(1'b1, 8'h53, 1'b0);
    chk("step_wait_en", {79'd0, en}, 80'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8'h4E, 1'b0);
      chk($sformatf("step%0d_pulse", k), {79'd0, en}, 80'd1);
      step(k == 1, 8'h43, 1'b0);
      chk($sformatf("step%0d_end", k), {79'd0, en}, 80'd0);
      all_on = 1'b0;
      repeat (4) begin
        step(1'b0, 8'h00, 1'b0);
        if (en) all_on = 1'b1;
      end
      chk($sformatf("step%0d_gap", k), {79'd0, all_on}, 80'd0);
    end
    chk("step_cnt", {48'd0, cnt}, 80'd3);
    step(1'b1, 8'h43, 1'b0);
    all_on = en;
    repeat (5) begin
      step(1'b0, 8'h00, 1'b0);
      all_on = all_on & en;
    end
    chk("step_to_run", {47'd0, all_on, cnt}, {47'd0, 1'b1, 32'd8});

    // reset mid-load discards the partial word
    do_reset();
    step(1'b1, 8'h4C, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    do_reset();
    step(1'b1, 8'h4C, 1'b0);
    step(1'b1, 8'h43, 1'b0);
    step(1'b1, 8'h53, 1'b0);
    chk("reload_no_we", {79'd0, we}, 80'd0);
    step(1'b1, 8'h4E, 1'b0);
    step(1'b1, 8'h52, 1'b0);
    chk("reload_word", {39'd0, we, addr, instr},
        {39'd0, 1'b1, 8'h00, 32'h43534E52});
    chk("reload_no_run", {78'd0, en, done}, 80'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
